ad1939_dac_serializer: RTL and testbench



---
 rtl/ad1939_dac_serializer.sv | 117 +++++++++++
 tb/tb_ad1939_dac_serializer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ad1939_dac_serializer.sv
// AD1939 DAC serial port master: 24-bit L/R stream in, I2S bit clock, LR clock and data out.
// Define AD1939_TX_UNDERRUN_REPEAT_EN to repeat the last pair on underrun; otherwise silence.
module ad1939_dac_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_channel,
   input  logic                  in_valid,
   output logic                  dsdata,
   output logic                  dbclk,
   output logic                  dlrclk,
   output logic                  frame_tick,
   output logic [15:0]           underrun_count
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W      = $clog2(FRAME_BITS);

   logic [DIV_W-1:0]      div_cnt;
   logic [DIV_W-1:0]      div_nxt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_nxt;
   logic [BIT_W-1:0]      slot_bit;
   logic                  div_wrap;
   logic                  frame_start;
   logic                  right_slot;
   logic                  data_nxt;
   logic [DATA_WIDTH-1:0] slot_sample;
   logic [DATA_WIDTH-1:0] pend_left;
   logic [DATA_WIDTH-1:0] pend_right;
   logic [DATA_WIDTH-1:0] active_left;
   logic [DATA_WIDTH-1:0] active_right;
   logic                  pend_left_v;
   logic                  pend_right_v;

   // Outputs are registered from next-state counters so they always match div_cnt/bit_cnt.
   always_comb begin
      div_wrap    = (div_cnt == DIV_W'(BCLK_DIV - 1));
      frame_start = div_wrap && (bit_cnt == BIT_W'(FRAME_BITS - 1));
      div_nxt     = div_wrap ? '0 : div_cnt + DIV_W'(1);
      bit_nxt     = bit_cnt;
      if (div_wrap) begin
         bit_nxt = frame_start ? '0 : bit_cnt + BIT_W'(1);
      end
      right_slot  = (bit_nxt >= BIT_W'(SLOT_BITS));
      slot_bit    = right_slot ? bit_nxt - BIT_W'(SLOT_BITS) : bit_nxt;
      slot_sample = right_slot ? active_right : active_left;
      data_nxt    = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (slot_bit == BIT_W'(DATA_WIDTH - i)) begin
            data_nxt = slot_sample[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt        <= '0;
         bit_cnt        <= '0;
         dbclk          <= 1'b0;
         dlrclk         <= 1'b0;
         dsdata         <= 1'b0;
         frame_tick     <= 1'b0;
         underrun_count <= '0;
         pend_left      <= '0;
         pend_right     <= '0;
         pend_left_v    <= 1'b0;
         pend_right_v   <= 1'b0;
         active_left    <= '0;
         active_right   <= '0;
      end else begin
         div_cnt    <= div_nxt;
         bit_cnt    <= bit_nxt;
         dbclk      <= (div_nxt >= DIV_W'(BCLK_DIV / 2));
         dlrclk     <= right_slot;
         dsdata     <= data_nxt;
         frame_tick <= frame_start;

         if (frame_start) begin
            if (pend_left_v && pend_right_v) begin
               active_left  <= pend_left;
               active_right <= pend_right;
            end else begin
               if (underrun_count != 16'hFFFF) begin
                  underrun_count <= underrun_count + 16'd1;
               end
`ifdef AD1939_TX_UNDERRUN_REPEAT_EN
               active_left  <= active_left;
               active_right <= active_right;
`else
               active_left  <= '0;
               active_right <= '0;
`endif
            end
            pend_left_v  <= 1'b0;
            pend_right_v <= 1'b0;
         end

         // Placed after the transfer so a write on the frame-start edge survives the flag clear.
         if (in_valid) begin
            if (in_channel) begin
               pend_right   <= in_data;
               pend_right_v <= 1'b1;
            end else begin
               pend_left    <= in_data;
               pend_left_v  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ad1939_dac_serializer.sv
// Directed bench for ad1939_dac_serializer: frame timing, I2S layout, underrun policy, reset.
module tb_ad1939_dac_serializer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] in_data;
   logic        in_channel;
   logic        in_valid;
   logic        dsdata;
   logic        dbclk;
   logic        dlrclk;
   logic        frame_tick;
   logic [15:0] underrun_count;

   int n_cmp = 0;
   int n_err = 0;

   int          wr_off[$];
   logic        wr_ch[$];
   logic [23:0] wr_dat[$];

   logic [23:0] ur_l;
   logic [23:0] ur_r;

   ad1939_dac_serializer #(.DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_data        (in_data),
      .in_channel     (in_channel),
      .in_valid       (in_valid),
      .dsdata         (dsdata),
      .dbclk          (dbclk),
      .dlrclk         (dlrclk),
      .frame_tick     (frame_tick),
      .underrun_count (underrun_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input int off, input logic ch, input logic [23:0] dat);
      wr_off.push_back(off);
      wr_ch.push_back(ch);
      wr_dat.push_back(dat);
   endtask

   // Entered at the negedge of frame offset 0; walks one 256-cycle frame.
   task automatic run_frame(input string name, input logic [23:0] l, input logic [23:0] r,
                            input logic tick, input logic [15:0] cnt);
      logic [63:0] pat;
      pat = {1'b0, l, 7'b0, 1'b0, r, 7'b0};
      for (int off = 0; off < 256; off++) begin
         chk({name, " dsdata"}, 32'(dsdata), 32'(pat[6'(63 - off / 4)]));
         chk({name, " dbclk"}, 32'(dbclk), 32'((off % 4) >= 2));
         chk({name, " dlrclk"}, 32'(dlrclk), 32'(off >= 128));
         chk({name, " frame_tick"}, 32'(frame_tick), 32'((off == 0) && tick));
         if (off == 0 || off == 255) chk({name, " underrun_count"}, 32'(underrun_count), 32'(cnt));
         in_valid = 1'b0;
         for (int i = 0; i < wr_off.size(); i++) begin
            if (wr_off[i] == off) begin
               in_valid   = 1'b1;
               in_channel = wr_ch[i];
               in_data    = wr_dat[i];
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wr_off.delete();
      wr_ch.delete();
      wr_dat.delete();
   endtask

   initial begin
      in_valid   = 1'b0;
      in_channel = 1'b0;
      in_data    = '0;
`ifdef AD1939_TX_UNDERRUN_REPEAT_EN
      ur_l = 24'h800001;
      ur_r = 24'h7FFFFE;
`else
      ur_l = 24'h000000;
      ur_r = 24'h000000;
`endif
      repeat (3) @(negedge clk);
      chk("rst dsdata", 32'(dsdata), 32'd0);
      chk("rst dbclk", 32'(dbclk), 32'd0);
      chk("rst dlrclk", 32'(dlrclk), 32'd0);
      chk("rst frame_tick", 32'(frame_tick), 32'd0);
      chk("rst underrun_count", 32'(underrun_count), 32'd0);
      reset_n = 1'b1;

      // Initial frame: zeros, no tick; load a full pair for the next frame.
      push_wr(10, 1'b0, 24'h800001);
      push_wr(20, 1'b1, 24'h7FFFFE);
      run_frame("f0", 24'h0, 24'h0, 1'b0, 16'd0);

      push_wr(30, 1'b0, 24'h123456);
      run_frame("f1", 24'h800001, 24'h7FFFFE, 1'b1, 16'd0);

      // Left-only underrun above; left pending again, then right on the tick cycle.
      push_wr(40, 1'b0, 24'h111111);
      run_frame("f2", ur_l, ur_r, 1'b1, 16'd1);

      push_wr(0, 1'b1, 24'h222222);
      push_wr(50, 1'b0, 24'h333333);
      run_frame("f3", ur_l, ur_r, 1'b1, 16'd2);

      // Overwrite left, then a right write on the transfer edge that must carry over.
      push_wr(60, 1'b0, 24'h000010);
      push_wr(70, 1'b0, 24'h000020);
      push_wr(80, 1'b1, 24'h00FFFF);
      push_wr(255, 1'b1, 24'h444444);
      run_frame("f4", 24'h333333, 24'h222222, 1'b1, 16'd2);

      push_wr(5, 1'b0, 24'h555555);
      run_frame("f5", 24'h000020, 24'h00FFFF, 1'b1, 16'd2);

      run_frame("f6", 24'h555555, 24'h444444, 1'b1, 16'd2);

`ifdef AD1939_TX_UNDERRUN_REPEAT_EN
      run_frame("f7", 24'h555555, 24'h444444, 1'b1, 16'd3);
`else
      run_frame("f7", 24'h000000, 24'h000000, 1'b1, 16'd3);
`endif

      // Mid-frame asynchronous reset.
      repeat (130) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("pre dbclk", 32'(dbclk), 32'd1);
      chk("pre dlrclk", 32'(dlrclk), 32'd1);
      chk("pre underrun_count", 32'(underrun_count), 32'd4);
      #2 reset_n = 1'b0;
      #1;
      chk("async dsdata", 32'(dsdata), 32'd0);
      chk("async dbclk", 32'(dbclk), 32'd0);
      chk("async dlrclk", 32'(dlrclk), 32'd0);
      chk("async frame_tick", 32'(frame_tick), 32'd0);
      chk("async underrun_count", 32'(underrun_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      run_frame("r0", 24'h0, 24'h0, 1'b0, 16'd0);
      run_frame("r1", 24'h0, 24'h0, 1'b1, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
